// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions: default bus widths, interrupt vectors and fetch states.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned CPU_DATA_W = 8;

    localparam logic [15:0] VECTOR_RESET = 16'hFFFC;
    localparam logic [15:0] VECTOR_NMI   = 16'hFFFA;
    localparam logic [15:0] VECTOR_IRQ   = 16'hFFFE;

    typedef enum logic [1:0] {
        VEC_LO,
        VEC_HI,
        RUN
    } fetch_state_t;

    typedef enum logic [1:0] {
        VEC_KIND_RESET,
        VEC_KIND_NMI,
        VEC_KIND_IRQ
    } vec_kind_t;

    // Low-byte address of the vector for a given entry kind
    function automatic logic [15:0] vector_of(input vec_kind_t kind);
        case (kind)
            VEC_KIND_NMI: return VECTOR_NMI;
            VEC_KIND_IRQ: return VECTOR_IRQ;
            default:      return VECTOR_RESET;
        endcase
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Fetch-unit bundle: memory read port, bus arbitration, redirect and decode-side byte stream.
interface cpu_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_busy;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_byte;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;

    modport master (
        output mem_addr, mem_req, out_valid, out_byte, out_pc, pc, count,
        input  mem_rdata, bus_busy, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_addr, mem_req, out_valid, out_byte, out_pc, pc, count,
        output mem_rdata, bus_busy, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {address, byte} entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_c;
    logic             push_c;

    // A full queue still accepts a push when the head leaves in the same cycle
    assign pop_c  = pop & (count != '0);
    assign push_c = push & ((count < CNT_W'(DEPTH)) | pop_c);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch front end: optional reset-vector load, then streams tagged bytes into the prefetch queue.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned         ADDR_W      = CPU_ADDR_W,
    parameter int unsigned         DATA_W      = CPU_DATA_W,
    parameter int unsigned         DEPTH       = 4,
    parameter bit                  VECTOR_EN   = 1'b1,
    parameter logic [ADDR_W-1:0]   VECTOR_ADDR = ADDR_W'(VECTOR_RESET),
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cpu_fetch_unit_if.master       bus
);
    localparam int unsigned  CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned  ENT_W = ADDR_W + DATA_W;
    localparam fetch_state_t RST_STATE = VECTOR_EN ? VEC_LO : RUN;
    localparam logic [ADDR_W-1:0] RST_PC = VECTOR_EN ? '0 : RESET_PC;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_nxt;
    logic [ADDR_W-1:0] addr_c;
    logic              req_c;
    logic              push_c;
    logic              flush_c;
    logic              pop_c;
    logic              room_c;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;

    assign pop_c  = bus.out_valid & bus.out_ready;
    assign room_c = (count < CNT_W'(DEPTH)) | pop_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RST_STATE;
            pc_q  <= RST_PC;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            lo_q  <= lo_nxt;
        end
    end

    // Redirect outranks bus_busy and fetch; reset suppresses any bus request
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        lo_nxt    = lo_q;
        addr_c    = pc_q;
        req_c     = 1'b0;
        push_c    = 1'b0;
        flush_c   = 1'b0;
        case (state)
            VEC_LO: begin
                addr_c = VECTOR_ADDR;
                if (!bus.bus_busy) begin
                    req_c     = 1'b1;
                    lo_nxt    = bus.mem_rdata;
                    state_nxt = VEC_HI;
                end
            end
            VEC_HI: begin
                addr_c = VECTOR_ADDR + ADDR_W'(1);
                if (!bus.bus_busy) begin
                    req_c     = 1'b1;
                    pc_nxt    = ADDR_W'({bus.mem_rdata, lo_q});
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    flush_c = 1'b1;
                    pc_nxt  = bus.redirect_pc;
                end else if (!bus.bus_busy && room_c) begin
                    req_c  = 1'b1;
                    push_c = 1'b1;
                    pc_nxt = pc_q + ADDR_W'(1);
                end
            end
            default: state_nxt = RST_STATE;
        endcase
        if (!rst_n) begin
            req_c  = 1'b0;
            push_c = 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush_c),
        .din   ({pc_q, bus.mem_rdata}),
        .count (count),
        .head  (head)
    );

    assign bus.mem_addr  = addr_c;
    assign bus.mem_req   = req_c;
    assign bus.pc        = pc_q;
    assign bus.count     = count;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = head[ENT_W-1:DATA_W];
    assign bus.out_byte  = head[DATA_W-1:0];

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios plus random traffic against a queue-based reference.
module tb_cpu_fetch_unit;

    logic clk;
    logic rst_v;
    logic rst_p;

    int checks = 0;
    int errors = 0;

    cpu_fetch_unit_if bus_v ();
    cpu_fetch_unit_if bus_p ();

    cpu_fetch_unit dut_v (
        .clk   (clk),
        .rst_n (rst_v),
        .bus   (bus_v)
    );

    cpu_fetch_unit #(
        .VECTOR_EN (1'b0),
        .RESET_PC  (16'hFFFE)
    ) dut_p (
        .clk   (clk),
        .rst_n (rst_p),
        .bus   (bus_p)
    );

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        case (a)
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'h1234: return 8'hA9;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    assign bus_v.mem_rdata = mem_fn(bus_v.mem_addr);
    assign bus_p.mem_rdata = mem_fn(bus_p.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a queue of {address, byte}, a fetch pointer, and the number of vector bytes still to read
    logic [23:0] mq[$];
    logic [15:0] m_pc;
    logic [7:0]  m_lo;
    int          vec_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_req();
        if (!rst_v) return 1'b0;
        if (vec_left > 0) return !bus_v.bus_busy;
        return !bus_v.bus_busy && !bus_v.redirect_valid &&
               (mq.size() < 4 || (mq.size() > 0 && bus_v.out_ready));
    endfunction

    function automatic logic [15:0] exp_addr();
        if (vec_left == 2) return 16'hFFFC;
        if (vec_left == 1) return 16'hFFFD;
        return m_pc;
    endfunction

    task automatic model_step();
        logic pop;
        logic fetch;
        if (!rst_v) begin
            mq.delete();
            vec_left = 2;
            m_pc     = 16'h0000;
        end else if (vec_left == 2) begin
            if (!bus_v.bus_busy) begin
                m_lo     = mem_fn(16'hFFFC);
                vec_left = 1;
            end
        end else if (vec_left == 1) begin
            if (!bus_v.bus_busy) begin
                m_pc     = {mem_fn(16'hFFFD), m_lo};
                vec_left = 0;
            end
        end else if (bus_v.redirect_valid) begin
            mq.delete();
            m_pc = bus_v.redirect_pc;
        end else begin
            pop   = (mq.size() > 0) && bus_v.out_ready;
            fetch = !bus_v.bus_busy && (mq.size() < 4 || pop);
            if (pop) void'(mq.pop_front());
            if (fetch) begin
                mq.push_back({m_pc, mem_fn(m_pc)});
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic check_regs();
        logic [23:0] ent;
        check("count", 32'(bus_v.count), 32'(mq.size()));
        check("out_valid", 32'(bus_v.out_valid), 32'(mq.size() != 0));
        check("pc", 32'(bus_v.pc), 32'(m_pc));
        if (mq.size() > 0) begin
            ent = mq[0];
            check("out_pc", 32'(bus_v.out_pc), 32'(ent[23:8]));
            check("out_byte", 32'(bus_v.out_byte), 32'(ent[7:0]));
        end
    endtask

    task automatic set_in(input logic rst, input logic busy, input logic redir,
                          input logic [15:0] rpc, input logic ready);
        rst_v                = rst;
        bus_v.bus_busy       = busy;
        bus_v.redirect_valid = redir;
        bus_v.redirect_pc    = rpc;
        bus_v.out_ready      = ready;
        #1;
        check("mem_req", 32'(bus_v.mem_req), 32'(exp_req()));
        if (exp_req()) check("mem_addr", 32'(bus_v.mem_addr), 32'(exp_addr()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    logic [15:0] saved_pc;
    logic [15:0] wrap_pc [4];

    initial begin
        vec_left = 2;
        m_pc     = 16'h0000;
        m_lo     = 8'h00;
        rst_p    = 1'b0;
        bus_p.bus_busy       = 1'b0;
        bus_p.redirect_valid = 1'b0;
        bus_p.redirect_pc    = 16'h0000;
        bus_p.out_ready      = 1'b0;
        wrap_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        check("rst_count", 32'(bus_v.count), 32'd0);
        check("rst_valid", 32'(bus_v.out_valid), 32'd0);

        // Vector load
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("vec_lo_addr", 32'(bus_v.mem_addr), 32'hFFFC);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("vec_hi_addr", 32'(bus_v.mem_addr), 32'hFFFD);
        tick();
        check("vec_pc", 32'(bus_v.pc), 32'h1234);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("first_req", 32'(bus_v.mem_req), 32'd1);
        tick();
        check("first_byte", 32'(bus_v.out_byte), 32'hA9);
        check("first_pc", 32'(bus_v.out_pc), 32'h1234);

        // Backpressure from 0x0200
        set_in(1'b1, 1'b0, 1'b1, 16'h0200, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
            tick();
        end
        check("bp_count", 32'(bus_v.count), 32'd4);
        check("bp_pc", 32'(bus_v.pc), 32'h0204);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("bp_noreq", 32'(bus_v.mem_req), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            check("stream_pc", 32'(bus_v.out_pc), 32'(16'h0200 + 16'(i)));
            tick();
            check("stream_count", 32'(bus_v.count), 32'd4);
        end

        // Bus busy: drop to 3, then three busy cycles drain the queue
        set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        tick();
        check("busy_count3", 32'(bus_v.count), 32'd3);
        saved_pc = bus_v.pc;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
            check("busy_noreq", 32'(bus_v.mem_req), 32'd0);
            tick();
            check("busy_pc", 32'(bus_v.pc), 32'(saved_pc));
        end
        check("busy_drained", 32'(bus_v.count), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("resume_addr", 32'(bus_v.mem_addr), 32'(saved_pc));
        tick();
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        check("redir_pre_count", 32'(bus_v.count), 32'd3);

        // Redirect with a pop in the same cycle
        set_in(1'b1, 1'b0, 1'b1, 16'h8000, 1'b1);
        tick();
        check("redir_count", 32'(bus_v.count), 32'd0);
        check("redir_valid", 32'(bus_v.out_valid), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("redir_addr", 32'(bus_v.mem_addr), 32'h8000);
        check("redir_req", 32'(bus_v.mem_req), 32'd1);
        tick();
        check("redir_head", 32'(bus_v.out_pc), 32'h8000);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        check("mid_pre_count", 32'(bus_v.count), 32'd2);

        // Reset mid-run
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        check("mid_count", 32'(bus_v.count), 32'd0);
        check("mid_valid", 32'(bus_v.out_valid), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("mid_vec_addr", 32'(bus_v.mem_addr), 32'hFFFC);
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                              : 16'($urandom);
            set_in(($urandom_range(0, 63) != 0),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 15) == 0),
                   rpc,
                   ($urandom_range(0, 1) == 1));
            tick();
        end

        // PC wrap on the RESET_PC instance
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        rst_p = 1'b1;
        check("wrap_rst_pc", 32'(bus_p.pc), 32'hFFFE);
        check("wrap_rst_count", 32'(bus_p.count), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_count", 32'(bus_p.count), 32'd4);
        check("wrap_pc", 32'(bus_p.pc), 32'h0002);
        bus_p.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wrap_out_pc", 32'(bus_p.out_pc), 32'(wrap_pc[i]));
            check("wrap_out_byte", 32'(bus_p.out_byte), 32'(mem_fn(wrap_pc[i])));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_unit.md
# cpu_fetch_unit

Parametrised instruction-fetch front end for the 6502 core. It sits between the memory bus and the decode stage. It replaces the single-byte fetch register with a configurable-depth prefetch queue that tags every byte with its address. It also adds optional reset-vector loading, control-flow redirect with queue flush, and yielding of the bus to execute-stage load/store accesses.

## Interface
- ADDR_W, 16, address and PC width
- DATA_W, 8, memory data / instruction byte width
- DEPTH, 4, prefetch queue entries; power of two, at least 2
- VECTOR_EN, 1, 1 = load PC from reset vector after reset; 0 = start at RESET_PC
- VECTOR_ADDR, 16'hFFFC, low-byte address of reset vector; high byte at VECTOR_ADDR+1
- RESET_PC, 16'h0000, start PC when VECTOR_EN=0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- mem_addr  out  ADDR_W  fetch address; meaningful only while mem_req=1
- mem_req  out  1  fetch read performed this cycle
- mem_rdata  in  DATA_W  read data; valid in the same cycle as mem_addr (combinational memory)
- bus_busy  in  1  execute stage owns the bus this cycle; no fetch allowed
- redirect_valid  in  1  jump/branch/interrupt taken; flush and reload
- redirect_pc  in  ADDR_W  new fetch PC
- out_valid  out  1  queue head valid
- out_byte  out  DATA_W  head instruction byte
- out_pc  out  ADDR_W  address of head byte
- out_ready  in  1  decode consumes head (pop = out_valid & out_ready)
- pc  out  ADDR_W  next fetch address
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
States are VEC_LO, VEC_HI and RUN.
- **Reset:**
  - count=0, out_valid=0, mem_req=0.
  - With VECTOR_EN=1: state=VEC_LO, pc=0.
  - With VECTOR_EN=0: state=RUN, pc=RESET_PC.
- **VEC_LO:**
  - mem_addr=VECTOR_ADDR.
  - If !bus_busy: mem_req=1, latch the low byte, go to VEC_HI.
  - Otherwise hold the state.
- **VEC_HI:**
  - mem_addr=VECTOR_ADDR+1.
  - If !bus_busy: pc={mem_rdata, low byte}, go to RUN.
  - redirect_valid is ignored in both VEC states.
- **RUN:**
  - Fetch condition: fetch = !bus_busy & !redirect_valid & (count<DEPTH | pop).
  - mem_addr=pc and mem_req=fetch.
  - On fetch, push {pc, mem_rdata} and set pc=pc+1, wrapping modulo 2^ADDR_W (0xFFFF→0x0000).
- **Simultaneous push and pop:** count is unchanged. This covers the full-queue case, so sustained throughput is 1 byte/cycle at count=DEPTH.
- **Redirect:**
  - Queue cleared (count=0, out_valid=0 next cycle), pc=redirect_pc.
  - No push that cycle.
  - A pop in the same cycle is discarded; decode treats redirect as its own flush.
  - Redirect beats bus_busy and fetch.
- **Empty queue:** out_valid=0 and out_byte/out_pc are don't-care. There is no bypass.
- **Reset mid-operation:** the queue is dropped and the state machine restarts in VEC_LO (or RUN at RESET_PC).

## Timing
- Fetch at edge N: the byte is at the head by edge N+1 when the queue was empty, so out_valid=1 in cycle N+1.
- Redirect at edge N: pc=redirect_pc in cycle N+1, with mem_req=1 (if !bus_busy). The first redirected byte appears at the head in cycle N+2.
- Vector load takes 2 non-busy cycles. The first opcode fetch is in the third cycle and is visible at the head in the fourth.
- bus_busy: mem_req=0 in the same cycle and pc is held; pops continue.
- count and out_* are registered. mem_addr and mem_req are combinational from state, pc, bus_busy, redirect_valid and count.

## Structure
- Shared package cpu_pkg:
  - ADDR_W/DATA_W defaults
  - VECTOR_RESET=16'hFFFC, VECTOR_NMI=16'hFFFA, VECTOR_IRQ=16'hFFFE
  - fetch-state enum {VEC_LO, VEC_HI, RUN}
- Sub-module fetch_fifo:
  - Synchronous FIFO with width ADDR_W+DATA_W and depth DEPTH.
  - Ports: push, pop, flush, count, head.
  - Wrap-around read/write pointers of $clog2(DEPTH) bits.
- cpu_fetch_unit holds the state machine, the PC and the fetch-condition logic.

## Test plan
1. **Vector load:** VECTOR_EN=1, mem[FFFC]=0x34, mem[FFFD]=0x12, mem[1234]=0xA9 → mem_addr FFFC then FFFD; pc=0x1234 in cycle 3; head out_byte=0xA9, out_pc=0x1234 in cycle 4.
2. **Backpressure:** DEPTH=4, out_ready=0 from PC 0x0200 → count reaches 4, mem_req=0, pc=0x0204. Then out_ready=1 held → one pop and one push per cycle, count stays 4, out_pc increments 0x0200, 0x0201, …
3. **Bus busy:** bus_busy=1 for 3 cycles with out_ready=1 and count=3 → mem_req=0 and pc frozen; count drops 3→0; fetching resumes at the same pc.
4. **Redirect:** redirect_valid=1 with redirect_pc=0x8000 while count=3 and a pop is asserted → next cycle count=0, out_valid=0, mem_addr=0x8000; following cycle out_pc=0x8000.
5. **PC wrap:** VECTOR_EN=0, RESET_PC=0xFFFE → out_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. **Reset mid-run:** rst_n=0 for 1 cycle with count=2 → count=0 and out_valid=0 next cycle; mem_addr=0xFFFC restarts the vector sequence.
